// File: rtl/led_seq_pkg.sv
// Shared mode encodings, LED patterns and mode-request decode for the LED sequencer.
package led_seq_pkg;

    localparam int unsigned LED_W  = 4;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS  = 2'b00,
        MODE_BLINK = 2'b01,
        MODE_CHASE = 2'b10
    } mode_e;

    localparam logic [LED_W-1:0] BLINK_OFF  = 4'b0000;
    localparam logic [LED_W-1:0] BLINK_ON   = 4'b1001;
    localparam logic [LED_W-1:0] CHASE_INIT = 4'b0001;

    // Fixed-priority decode: blink beats chase, otherwise pass-through.
    function automatic mode_e req_mode(input logic [LED_W-1:0] ps);
        if (ps[0] && ps[3]) begin
            return MODE_BLINK;
        end else if (ps[1] && ps[2]) begin
            return MODE_CHASE;
        end
        return MODE_PASS;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_if.sv
// Switch inputs and LED-side outputs of the sequencer bundled as one port.
interface led_mode_sequencer_if;
    import led_seq_pkg::*;

    logic [LED_W-1:0]  P;
    logic [LED_W-1:0]  Led;
    logic [MODE_W-1:0] mode;
    logic              tick;

    modport master (output P, input Led, input mode, input tick);
    modport slave  (input P, output Led, output mode, output tick);
endinterface

// File: rtl/led_tick_gen.sv
// Half-period prescaler: counts 0..HALF_PERIOD-1 while enabled, strobes tick on the last count.
module led_tick_gen #(
    parameter int unsigned HALF_PERIOD = 25000000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

    // Step strobe for the cycle whose edge advances the pattern.
    assign tick = en && (cnt == LAST);

    // Counter clears on mode entry, wraps on tick, and sits at zero when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// LED bank sequencer: pass-through, two-phase blink or rotating chase selected by P.
// Optional build macro: LED_SEQ_SYNC_EN adds a 2-flop synchronizer on P.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 25000000,
    parameter int unsigned CNT_W       = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    led_mode_sequencer_if.slave   bus
);

    logic [LED_W-1:0] ps;
    mode_e            mode_q;
    mode_e            mode_d;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] led_d;
    logic             phase_q;
    logic             phase_d;
    logic             clr;
    logic             en;
    logic             tick;

`ifdef LED_SEQ_SYNC_EN
    logic [LED_W-1:0] sync1_q;
    logic [LED_W-1:0] sync2_q;

    // Two-flop synchronizer for asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.P;
            sync2_q <= sync1_q;
        end
    end

    assign ps = sync2_q;
`else
    assign ps = bus.P;
`endif

    led_tick_gen #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (en),
        .cnt  (),
        .tick (tick)
    );

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_PASS;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode follows the requested mode directly; any mode may follow any other.
    always_comb begin
        mode_d = mode_q;
        mode_d = req_mode(ps);
    end

    // Pattern next-value logic; a mode change overrides a coincident tick.
    always_comb begin
        led_d   = led_q;
        phase_d = phase_q;
        clr     = (mode_d != mode_q);
        en      = (mode_q != MODE_PASS);
        if (clr) begin
            phase_d = 1'b0;
            case (mode_d)
                MODE_PASS:  led_d = ps;
                MODE_BLINK: led_d = BLINK_OFF;
                MODE_CHASE: led_d = CHASE_INIT;
                default:    led_d = '0;
            endcase
        end else begin
            case (mode_q)
                MODE_PASS: begin
                    led_d   = ps;
                    phase_d = 1'b0;
                end
                MODE_BLINK: begin
                    if (tick) begin
                        phase_d = ~phase_q;
                        led_d   = phase_q ? BLINK_OFF : BLINK_ON;
                    end
                end
                MODE_CHASE: begin
                    if (tick) begin
                        led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    end
                end
                default: begin
                    led_d   = '0;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    // LED drive and blink phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            phase_q <= phase_d;
        end
    end

    assign bus.Led  = led_q;
    assign bus.mode = mode_q;
    assign bus.tick = tick;

endmodule
